cache_axi_rd_arbiter: RTL and testbench

CACHE_AXI_RD_ARBITER -- requirements
Module: cache_axi_rd_arbiter

---
 rtl/cache_axi_rd_arbiter.sv | 127 ++++++++++++
 tb/tb_cache_axi_rd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_rd_arbiter.sv
// Two-port (instruction/data cache) read arbiter onto a single AXI read channel.
// Exactly one transaction outstanding; round-robin on simultaneous requests.
module cache_axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [3:0]        i_arlen,
    input  logic              i_arvalid,
    output logic              i_arready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    output logic              i_rvalid,
    input  logic              i_rready,

    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [3:0]        d_arlen,
    input  logic              d_arvalid,
    output logic              d_arready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,

    output logic [3:0]        m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [3:0]        m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic              proto_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;      // 0 = instruction port, 1 = data port
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [3:0]        beat_q;
    logic              proto_err_q;
    logic              in_data;
    logic              beat_fire;

    assign in_data   = (state_q == S_DATA);
    assign beat_fire = in_data && m_rvalid && m_rready;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        i_arready = 1'b0;
        d_arready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    // On a tie the port that did not win last time is served.
                    grant_d   = (i_arvalid && d_arvalid) ? ~last_grant_q : d_arvalid;
                    i_arready = ~grant_d;
                    d_arready = grant_d;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (beat_fire && m_rlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_arvalid = (state_q == S_ADDR);
    assign m_arid    = {3'b000, grant_q};
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_rready  = in_data && (grant_q ? d_rready : i_rready);
    assign proto_err = proto_err_q;

    assign i_rvalid  = in_data && !grant_q && m_rvalid;
    assign i_rlast   = in_data && !grant_q && m_rlast;
    assign i_rdata   = (in_data && !grant_q) ? m_rdata : '0;
    assign d_rvalid  = in_data && grant_q && m_rvalid;
    assign d_rlast   = in_data && grant_q && m_rlast;
    assign d_rdata   = (in_data && grant_q) ? m_rdata : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && state_d == S_ADDR) begin
                grant_q <= grant_d;
                addr_q  <= grant_d ? d_araddr : i_araddr;
                len_q   <= grant_d ? d_arlen  : i_arlen;
            end
            if (state_q == S_ADDR && m_arready) beat_q <= '0;
            if (beat_fire) begin
                beat_q <= beat_q + 4'd1;
                // Length mismatch is only flagged; termination still follows m_rlast.
                if (m_rlast != (beat_q == len_q)) proto_err_q <= 1'b1;
                if (m_rlast) last_grant_q <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed self-checking bench for cache_axi_rd_arbiter: arbitration, AR stall,
// backpressure, protocol-error detection and mid-burst reset.
module tb_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_araddr, d_araddr, m_araddr;
    logic [3:0]  i_arlen, d_arlen, m_arlen, m_arid;
    logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
    logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
    logic [31:0] i_rdata, d_rdata, m_rdata;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .proto_err(proto_err)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        step();
        rst = 1'b1;
        i_arvalid = 1'b0; d_arvalid = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Single-port request: checks arready pulse, then the AR beat on the master side.
    task automatic request(input bit port, input logic [31:0] addr, input logic [3:0] len);
        step();
        if (port) begin d_arvalid = 1'b1; d_araddr = addr; d_arlen = len; end
        else      begin i_arvalid = 1'b1; i_araddr = addr; i_arlen = len; end
        @(negedge clk);
        checks++;
        if ({i_arready, d_arready, m_arvalid} !== {!port, port, 1'b0}) begin
            errors++;
            $display("FAIL req_grant port%0d: i/d_arready,m_arvalid=%b%b%b expected %b%b0",
                     port, i_arready, d_arready, m_arvalid, !port, port);
        end
        step();
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_arvalid, m_arid, m_araddr, m_arlen} !== {1'b1, 3'b000, port, addr, len}) begin
            errors++;
            $display("FAIL req_ar port%0d: valid=%b id=%0d addr=%h len=%0d expected 1/%0d/%h/%0d",
                     port, m_arvalid, m_arid, m_araddr, m_arlen, port, addr, len);
        end
    endtask

    // Drives nbeats beats (rready held high), checks routing of each, then the return to idle.
    task automatic serve(input bit port, input int nbeats, input logic [31:0] base);
        i_rready = 1'b1; d_rready = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            step();
            m_rvalid = 1'b1; m_rdata = base + b; m_rlast = (b == nbeats - 1);
            @(negedge clk);
            checks++;
            if (port ? ({d_rvalid, d_rdata, d_rlast, i_rvalid, m_rready, m_arvalid}
                        !== {1'b1, base + b, b == nbeats - 1, 1'b0, 1'b1, 1'b0})
                     : ({i_rvalid, i_rdata, i_rlast, d_rvalid, m_rready, m_arvalid}
                        !== {1'b1, base + b, b == nbeats - 1, 1'b0, 1'b1, 1'b0})) begin
                errors++;
                $display("FAIL beat port%0d #%0d: i_rv=%b i_d=%h i_l=%b d_rv=%b d_d=%h d_l=%b rr=%b expected data %h",
                         port, b, i_rvalid, i_rdata, i_rlast, d_rvalid, d_rdata, d_rlast, m_rready, base + b);
            end
        end
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_rvalid, d_rvalid, m_rready, m_arvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after port%0d: i_rv,d_rv,m_rready,m_arvalid=%b%b%b%b expected 0000",
                     port, i_rvalid, d_rvalid, m_rready, m_arvalid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({m_arvalid, i_arready, d_arready, proto_err, m_rready, i_rvalid, d_rvalid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b%b%b%b%b expected 0000000",
                     m_arvalid, i_arready, d_arready, proto_err, m_rready, i_rvalid, d_rvalid);
        end
    endtask

    task automatic test_single_i();
        m_arready = 1'b1;
        request(1'b0, 32'hBFC0_0000, 4'd15);
        serve(1'b0, 16, 32'h0000_1000);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL single_i_proto_err: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        m_arready = 1'b1;
        step();
        i_arvalid = 1'b1; i_araddr = 32'h100; i_arlen = 4'd1;
        d_arvalid = 1'b1; d_araddr = 32'h200; d_arlen = 4'd1;
        @(negedge clk);
        checks++;
        if ({i_arready, d_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rr_first: i/d_arready=%b%b expected 01", i_arready, d_arready);
        end
        step();
        d_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_arvalid, m_arid, m_araddr, i_arready} !== {1'b1, 4'd1, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL rr_d_ar: valid=%b id=%0d addr=%h i_arready=%b expected 1/1/200/0",
                     m_arvalid, m_arid, m_araddr, i_arready);
        end
        // i_arvalid stays high through the data burst; the IDLE cycle after it grants port 0.
        serve(1'b1, 2, 32'hD000_0000);
        checks++;
        if (i_arready !== 1'b1) begin
            errors++;
            $display("FAIL rr_second_grant: i_arready=%b expected 1", i_arready);
        end
        step();
        i_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_arvalid, m_arid, m_araddr} !== {1'b1, 4'd0, 32'h100}) begin
            errors++;
            $display("FAIL rr_i_ar: valid=%b id=%0d addr=%h expected 1/0/100", m_arvalid, m_arid, m_araddr);
        end
        serve(1'b0, 2, 32'h1000_0000);
    endtask

    task automatic test_ar_stall();
        m_arready = 1'b0;
        request(1'b1, 32'h300, 4'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 4) m_arready = 1'b1;
            @(negedge clk);
            checks++;
            if ({m_arvalid, m_araddr, m_arid} !== {1'b1, 32'h300, 4'd1}) begin
                errors++;
                $display("FAIL ar_stall cycle%0d: valid=%b addr=%h id=%0d expected 1/300/1",
                         c, m_arvalid, m_araddr, m_arid);
            end
        end
        serve(1'b1, 1, 32'h5555_0000);
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        m_arready = 1'b1;
        request(1'b1, 32'h400, 4'd3);
        while (idx < 4 && cyc < 40) begin
            step();
            d_rready = (cyc % 2 == 0);
            m_rvalid = 1'b1; m_rdata = 32'hA0 + idx; m_rlast = (idx == 3);
            @(negedge clk);
            checks++;
            if ({m_rready, d_rvalid, d_rdata, i_rvalid} !== {d_rready, 1'b1, 32'hA0 + idx, 1'b0}) begin
                errors++;
                $display("FAIL backpressure cyc%0d: m_rready=%b d_rvalid=%b d_rdata=%h expected %b/1/%h",
                         cyc, m_rready, d_rvalid, d_rdata, d_rready, 32'hA0 + idx);
            end
            if (d_rready) idx++;
            cyc++;
        end
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        @(negedge clk);
        checks++;
        if ({idx == 4, d_rvalid, m_rready, proto_err} !== 4'b1000) begin
            errors++;
            $display("FAIL backpressure_end: beats=%0d d_rvalid=%b m_rready=%b proto_err=%b expected 4/0/0/0",
                     idx, d_rvalid, m_rready, proto_err);
        end
    endtask

    task automatic test_proto_err();
        m_arready = 1'b1;
        d_rready = 1'b1;
        request(1'b1, 32'h500, 4'd0);
        step();
        m_rvalid = 1'b1; m_rdata = 32'h1; m_rlast = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_rvalid, proto_err} !== 2'b10) begin
            errors++;
            $display("FAIL proto_beat1: d_rvalid=%b proto_err=%b expected 1/0", d_rvalid, proto_err);
        end
        step();
        m_rdata = 32'h2; m_rlast = 1'b1;
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_rlast, proto_err} !== 3'b111) begin
            errors++;
            $display("FAIL proto_beat2: d_rvalid=%b d_rlast=%b proto_err=%b expected 1/1/1",
                     d_rvalid, d_rlast, proto_err);
        end
        step();
        m_rlast = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_rvalid, m_rready, proto_err} !== 3'b001) begin
            errors++;
            $display("FAIL proto_done: d_rvalid=%b m_rready=%b proto_err=%b expected 0/0/1",
                     d_rvalid, m_rready, proto_err);
        end
        m_rvalid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky: proto_err=%b expected 1", proto_err);
        end
    endtask

    task automatic test_mid_reset();
        m_arready = 1'b1;
        i_rready = 1'b1;
        request(1'b0, 32'h600, 4'd15);
        for (int b = 0; b < 7; b++) begin
            step();
            m_rvalid = 1'b1; m_rdata = 32'h60 + b; m_rlast = 1'b0;
            if (b == 6) rst = 1'b1;
        end
        step();
        rst = 1'b0;
        m_rdata = 32'h67;
        @(negedge clk);
        checks++;
        if ({m_arvalid, i_arready, d_arready, proto_err, i_rvalid, m_rready} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: arvalid=%b i_ar=%b d_ar=%b perr=%b i_rvalid=%b m_rready=%b expected 000000",
                     m_arvalid, i_arready, d_arready, proto_err, i_rvalid, m_rready);
        end
        step();
        m_rvalid = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h700; i_arlen = 4'd0;
        d_arvalid = 1'b1; d_araddr = 32'h800; d_arlen = 4'd0;
        @(negedge clk);
        checks++;
        if ({i_arready, d_arready} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant: i/d_arready=%b%b expected 01", i_arready, d_arready);
        end
        step();
        i_arvalid = 1'b0; d_arvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_arvalid, m_arid, m_araddr} !== {1'b1, 4'd1, 32'h800}) begin
            errors++;
            $display("FAIL post_reset_ar: valid=%b id=%0d addr=%h expected 1/1/800", m_arvalid, m_arid, m_araddr);
        end
        serve(1'b1, 1, 32'h8888_0000);
    endtask

    initial begin
        rst = 1'b1;
        i_araddr = '0; i_arlen = '0; i_arvalid = 1'b0; i_rready = 1'b0;
        d_araddr = '0; d_arlen = '0; d_arvalid = 1'b0; d_rready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        test_reset();
        test_single_i();
        test_round_robin();
        test_ar_stall();
        test_backpressure();
        test_proto_err();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
